// File: rtl/bless_inject_ctrl_if.sv
// ---------------------------------------------------------------------------
// bless_inject_ctrl_if
// Bundles the requester-side handshake and the router injection bus of the
// BLESS local-port-4 injection scheduler.
//
//   req_valid   [NREQ]       requester i holds a flit
//   req_c       [NREQ*22]    control word per requester, slice i = [i*22 +: 22]
//   req_d       [NREQ*128]   data word per requester, slice i = [i*128 +: 128]
//   req_ready   [NREQ]       grant back to the requesters (one-hot or zero)
//   port4_ready              router has a free injection slot this cycle
//   inj_c       [22]         to brouter port4_ci
//   inj_d       [128]        to brouter port4_di
//
// Modports: master = requesters + router side, slave = the scheduler.
// ---------------------------------------------------------------------------
interface bless_inject_ctrl_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*22-1:0]  req_c;
    logic [NREQ*128-1:0] req_d;
    logic [NREQ-1:0]     req_ready;
    logic                port4_ready;
    logic [21:0]         inj_c;
    logic [127:0]        inj_d;

    modport master (
        output req_valid, req_c, req_d, port4_ready,
        input  req_ready, inj_c, inj_d
    );

    modport slave (
        input  req_valid, req_c, req_d, port4_ready,
        output req_ready, inj_c, inj_d
    );
endinterface

// File: rtl/bless_inject_ctrl.sv
// ---------------------------------------------------------------------------
// bless_inject_ctrl
// Node-side injection scheduler for local port 4 of a bufferless (BLESS)
// router. NREQ local requesters share one injection slot through a
// round-robin arbiter; granted flits go into a shared DEPTH-entry FIFO whose
// head is driven to the router only in cycles where port4_ready is high.
//
// Ports:
//   clk      in   clock, all state on the rising edge
//   rst      in   asynchronous, active-low reset (0 = reset)
//   bus      slave modport of bless_inject_ctrl_if (requesters + inj bus)
//   count    out  FIFO occupancy, $clog2(DEPTH+1) bits
//   full     out  count == DEPTH
//   empty    out  count == 0
//   starve   out  head blocked for >= STARVE_LIMIT cycles
//
// Optional feature macro: BLESS_INJ_STARVE_EN enables the starvation counter.
// Without it, starve is tied to 0.
// ---------------------------------------------------------------------------
module bless_inject_ctrl #(
    parameter int NREQ         = 2,   // 2..8
    parameter int DEPTH        = 4,   // power of 2, >= 2
    parameter int STARVE_LIMIT = 16   // 1..255 (8-bit counter)
) (
    input  logic                       clk,
    input  logic                       rst,
    bless_inject_ctrl_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       starve
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH+1);

    // Bit 21 (flit valid) is always 1 for a stored flit, so only 20:0 is kept.
    logic [20:0]   mem_c [DEPTH];
    logic [127:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [PW-1:0] rr_ptr;

    logic [PW:0]   scan_sum;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic          push;
    logic          pop;
    logic [20:0]   push_c;
    logic [127:0]  push_d;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Round-robin scan starting at rr_ptr, wrapping modulo NREQ.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ))
                scan_sum = scan_sum - (PW+1)'(NREQ);
            scan_idx = scan_sum[PW-1:0];
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // No grant while full, even if the head pops this cycle; rst gating keeps
    // req_ready low while reset is asserted.
    assign push = grant_found && !full && rst;
    assign pop  = !empty && bus.port4_ready;

    always_comb begin
        bus.req_ready = '0;
        if (push)
            bus.req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        push_c = '0;
        push_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                push_c = bus.req_c[i*22 +: 21];
                push_d = bus.req_d[i*128 +: 128];
            end
        end
    end

    // Injection is driven only from the registered head, never bypassed.
    assign bus.inj_c = pop ? {1'b1, mem_c[rd_ptr]} : '0;
    assign bus.inj_d = pop ? mem_d[rd_ptr]         : '0;

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because the pointers and count are reset, and skipping it keeps the
    // array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_c[wr_ptr] <= push_c;
            mem_d[wr_ptr] <= push_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (grant_idx == PW'(NREQ-1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant_idx + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef BLESS_INJ_STARVE_EN
    logic [7:0] starve_cnt;
    logic [7:0] starve_cnt_nxt;

    // Saturating count of blocked cycles; cleared whenever the head leaves
    // or there is no head at all.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (empty || pop)
            starve_cnt_nxt = '0;
        else if (!bus.port4_ready && starve_cnt != 8'hFF)
            starve_cnt_nxt = starve_cnt + 8'd1;
    end

    // starve is registered from the next count, so it rises at the edge that
    // reaches the limit and falls at the edge of the pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            starve     <= (int'(starve_cnt_nxt) >= STARVE_LIMIT);
        end
    end
`else
    // Counter disabled: starve is constant 0 for any legal STARVE_LIMIT.
    if (STARVE_LIMIT >= 1) begin : g_starve_off
        assign starve = 1'b0;
    end
`endif

endmodule

// File: tb/tb_bless_inject_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for bless_inject_ctrl (NREQ=2, DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_bless_inject_ctrl;
    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef BLESS_INJ_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       starve;
    int         total = 0;
    int         bad   = 0;

    bless_inject_ctrl_if #(.NREQ(NREQ)) bus ();

    bless_inject_ctrl #(
        .NREQ(NREQ), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .count(count), .full(full), .empty(empty), .starve(starve)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic v, input logic [21:0] c, input logic [127:0] d);
        bus.req_valid[i]        = v;
        bus.req_c[i*22 +: 22]   = c;
        bus.req_d[i*128 +: 128] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid   = '0;
        bus.port4_ready = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    // T1: reset values, reset in the middle of traffic, first push after reset.
    task automatic test_reset();
        #2;
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
        total++; if (bus.inj_c !== 22'h0) begin bad++; $display("FAIL rst_inj_c: got %h want 0", bus.inj_c); end
        total++; if (bus.inj_d !== 128'h0) begin bad++; $display("FAIL rst_inj_d: got %h want 0", bus.inj_d); end
        total++; if ({full, empty, starve} !== 3'b010) begin bad++; $display("FAIL rst_flags: got full/empty/starve=%b want 010", {full, empty, starve}); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end

        step();
        rst = 1'b1;
        bus.port4_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 22'h0000A0, 128'hA1 + 128'(k));
            sample();
            total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL t1_fill_grant%0d: got %b want 01", k, bus.req_ready); end
            step();
        end
        sample();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL t1_count3: got %0d want 3", count); end

        #2;
        rst = 1'b0;
        bus.port4_ready = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL t1_async_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t1_async_empty: got %b want 1", empty); end
        total++; if (bus.inj_c !== 22'h0) begin bad++; $display("FAIL t1_async_inj_c: got %h want 0", bus.inj_c); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL t1_async_req_ready: got %b want 00", bus.req_ready); end

        step();
        rst = 1'b1;
        bus.port4_ready = 1'b0;
        set_req(0, 1'b1, 22'h0000B0, 128'hB0);
        sample();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL t1_post_grant: got %b want 01", bus.req_ready); end
        step();
        bus.req_valid   = '0;
        bus.port4_ready = 1'b1;
        sample();
        total++; if (bus.inj_c !== 22'h2000B0) begin bad++; $display("FAIL t1_post_inj_c: got %h want 2000b0", bus.inj_c); end
        total++; if (bus.inj_d !== 128'hB0) begin bad++; $display("FAIL t1_post_inj_d: got %h want b0", bus.inj_d); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL t1_post_count: got %0d want 1", count); end
        step();
        sample();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t1_post_empty: got %b want 1", empty); end
    endtask

    // T2: single flit, bit 21 forced, no same-cycle bypass.
    task automatic test_single();
        step();
        set_req(0, 1'b1, 22'h000801, 128'hDEAD_BEEF_0123_4567);
        bus.port4_ready = 1'b1;
        sample();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL t2_grant: got %b want 01", bus.req_ready); end
        total++; if (bus.inj_c !== 22'h0) begin bad++; $display("FAIL t2_no_bypass: got %h want 0", bus.inj_c); end
        step();
        bus.req_valid = '0;
        sample();
        total++; if (bus.inj_c !== 22'h200801) begin bad++; $display("FAIL t2_inj_c: got %h want 200801", bus.inj_c); end
        total++; if (bus.inj_d !== 128'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL t2_inj_d: got %h want deadbeef01234567", bus.inj_d); end
        step();
        sample();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t2_empty: got %b want 1", empty); end
        total++; if (bus.inj_c !== 22'h0) begin bad++; $display("FAIL t2_idle_inj_c: got %h want 0", bus.inj_c); end
    endtask

    // T3: round-robin between two always-valid requesters, then FIFO-order drain.
    task automatic test_round_robin();
        logic [1:0]   exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [21:0]  exp_c;
        logic [127:0] exp_d;
        do_reset();
        set_req(0, 1'b1, 22'h000011, 128'h10);
        set_req(1, 1'b1, 22'h200022, 128'h11);
        for (int i = 0; i < 4; i++) begin
            sample();
            total++; if (bus.req_ready !== exp_grant[i]) begin bad++; $display("FAIL t3_grant%0d: got %b want %b", i, bus.req_ready, exp_grant[i]); end
            step();
        end
        sample();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL t3_full: got %b want 1", full); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL t3_full_no_grant: got %b want 00", bus.req_ready); end
        step();
        bus.req_valid   = '0;
        bus.port4_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_c = (i % 2 == 1) ? 22'h200022 : 22'h200011;
            exp_d = (i % 2 == 1) ? 128'h11 : 128'h10;
            sample();
            total++; if (bus.inj_c !== exp_c) begin bad++; $display("FAIL t3_inj_c%0d: got %h want %h", i, bus.inj_c, exp_c); end
            total++; if (bus.inj_d !== exp_d) begin bad++; $display("FAIL t3_inj_d%0d: got %h want %h", i, bus.inj_d, exp_d); end
            step();
        end
        sample();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t3_empty: got %b want 1", empty); end
    endtask

    // T4: full backpressure; no grant in the pop cycle while full.
    task automatic test_full_backpressure();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            set_req(0, 1'b1, 22'h000100, 128'(k));
            sample();
            total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL t4_accept%0d: got %b want 01", k, bus.req_ready); end
            step();
        end
        set_req(0, 1'b1, 22'h000100, 128'd5);
        sample();
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL t4_reject5: got %b want 00", bus.req_ready); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL t4_full: got %b want 1", full); end
        step();
        bus.port4_ready = 1'b1;
        sample();
        total++; if (bus.inj_d !== 128'd1) begin bad++; $display("FAIL t4_inj1: got %h want 1", bus.inj_d); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL t4_no_grant_on_pop: got %b want 00", bus.req_ready); end
        step();
        sample();
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL t4_grant5: got %b want 01", bus.req_ready); end
        total++; if (bus.inj_d !== 128'd2) begin bad++; $display("FAIL t4_inj2: got %h want 2", bus.inj_d); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL t4_count3: got %0d want 3", count); end
        step();
        bus.req_valid = '0;
        for (int k = 3; k <= 5; k++) begin
            sample();
            total++; if (bus.inj_d !== 128'(k)) begin bad++; $display("FAIL t4_drain%0d: got %h want %0d", k, bus.inj_d, k); end
            step();
        end
        sample();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t4_empty: got %b want 1", empty); end
    endtask

    // T5: steady push+pop keeps count at 2 and preserves order.
    task automatic test_simul_push_pop();
        do_reset();
        set_req(1, 1'b1, 22'h000005, 128'h51);
        sample();
        step();
        set_req(1, 1'b1, 22'h000005, 128'h52);
        sample();
        step();
        bus.port4_ready = 1'b1;
        set_req(1, 1'b1, 22'h000005, 128'h53);
        for (int i = 0; i < 10; i++) begin
            sample();
            total++; if (count !== 3'd2) begin bad++; $display("FAIL t5_count%0d: got %0d want 2", i, count); end
            total++; if (bus.inj_d !== 128'h51 + 128'(i)) begin bad++; $display("FAIL t5_head%0d: got %h want %h", i, bus.inj_d, 128'h51 + 128'(i)); end
            total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL t5_grant%0d: got %b want 10", i, bus.req_ready); end
            step();
            set_req(1, 1'b1, 22'h000005, 128'h54 + 128'(i));
        end
        bus.req_valid = '0;
        sample();
        total++; if (bus.inj_d !== 128'h5B) begin bad++; $display("FAIL t5_drain0: got %h want 5b", bus.inj_d); end
        step();
        sample();
        total++; if (bus.inj_d !== 128'h5C) begin bad++; $display("FAIL t5_drain1: got %h want 5c", bus.inj_d); end
        step();
        sample();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t5_empty: got %b want 1", empty); end
    endtask

    // T6: starvation flag after LIMIT blocked edges (0 throughout without the macro).
    task automatic test_starve();
        logic exp_starve;
        do_reset();
        set_req(0, 1'b1, 22'h000000, 128'h77);
        sample();
        step();
        bus.req_valid = '0;
        sample();
        total++; if (starve !== 1'b0) begin bad++; $display("FAIL t6_starve_start: got %b want 0", starve); end
        total++; if (bus.inj_c !== 22'h0) begin bad++; $display("FAIL t6_blocked_inj_c: got %h want 0", bus.inj_c); end
        for (int i = 1; i <= LIMIT; i++) begin
            step();
            sample();
            exp_starve = STARVE_ON && (i >= LIMIT);
            total++; if (starve !== exp_starve) begin bad++; $display("FAIL t6_starve_edge%0d: got %b want %b", i, starve, exp_starve); end
        end
        step();
        bus.port4_ready = 1'b1;
        sample();
        total++; if (bus.inj_d !== 128'h77) begin bad++; $display("FAIL t6_inj: got %h want 77", bus.inj_d); end
        total++; if (starve !== STARVE_ON) begin bad++; $display("FAIL t6_starve_held: got %b want %b", starve, STARVE_ON); end
        step();
        sample();
        total++; if (starve !== 1'b0) begin bad++; $display("FAIL t6_starve_drop: got %b want 0", starve); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL t6_empty: got %b want 1", empty); end
    endtask

    initial begin
        rst             = 1'b0;
        bus.req_valid   = '0;
        bus.req_c       = '0;
        bus.req_d       = '0;
        bus.port4_ready = 1'b1;
        set_req(0, 1'b1, 22'h000123, 128'h99);

        test_reset();
        test_single();
        test_round_robin();
        test_full_backpressure();
        test_simul_push_pop();
        test_starve();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
